// File: rtl/step_gen_pkg.sv
// step_gen_pkg: shared encodings and hybrid activity profile constants for the step pulse generator.
package step_gen_pkg;
    typedef enum logic [1:0] {MODE_32, MODE_64, MODE_128, MODE_HYBRID} mode_e;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam logic [7:0] SEG_EARLY_END = 8'd9;
    localparam logic [7:0] SEG_MID_END = 8'd73;
    localparam logic [7:0] SEG_DIP_END = 8'd79;
    localparam logic [7:0] SEG_LATE_END = 8'd144;
    localparam logic [7:0] MID_RATE = 8'd69;
    localparam logic [7:0] DIP_RATE = 8'd34;
    localparam logic [7:0] LATE_RATE = 8'd124;
    // Entry [n] is the rate of second n+1.
    localparam logic [8:0][7:0] EARLY_RATE = {8'd33, 8'd30, 8'd19, 8'd30, 8'd70, 8'd27, 8'd66, 8'd33, 8'd20};
    localparam logic [7:0] HYBRID_LAST_SEC = 8'd144;
endpackage

// File: rtl/step_pulse_gen_if.sv
// step_pulse_gen_if: control and status bundle of the step pulse generator.
interface step_pulse_gen_if;
    import step_gen_pkg::*;
    logic start;
    mode_e mode;
    logic step_pulse;
    logic [7:0] rate;
    logic [7:0] sec_count;
    logic hybrid_done;
    modport master (output start, mode, input step_pulse, rate, sec_count, hybrid_done);
    modport slave (input start, mode, output step_pulse, rate, sec_count, hybrid_done);
endinterface

// File: rtl/step_rate_profile.sv
// step_rate_profile: maps (mode, 1-based second index) to a steps-per-second rate.
module step_rate_profile
    import step_gen_pkg::*;
(
    input  mode_e      mode_i,
    input  logic [7:0] sec_i,
    output logic [7:0] rate_o
);
    logic [3:0] early_idx;
    logic [7:0] hybrid_rate;

    assign early_idx = sec_i[3:0] - 4'd1;
    assign hybrid_rate = sec_i == 8'd0 ? 8'd0 :
                         sec_i <= SEG_EARLY_END ? EARLY_RATE[early_idx] :
                         sec_i <= SEG_MID_END ? MID_RATE :
                         sec_i <= SEG_DIP_END ? DIP_RATE :
                         sec_i <= SEG_LATE_END ? LATE_RATE : 8'd0;
    assign rate_o = mode_i == MODE_HYBRID ? hybrid_rate : 8'd32 << mode_i;
endmodule

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: emits evenly spaced single-cycle step pulses at a fixed or profiled rate.
module step_pulse_gen
    import step_gen_pkg::*;
#(
    parameter int CLK_HZ = 1000,
    parameter int CW = 10
) (
    input logic step_clk,
    input logic reset,
    step_pulse_gen_if.slave bus
);
    localparam logic [CW-1:0] HZ = CW'(CLK_HZ);
    localparam logic [CW-1:0] LAST_CYC = CW'(CLK_HZ - 1);

    state_e state_q, state_d;
    mode_e mode_q, mode_d, prof_mode;
    logic [CW-1:0] cyc_q, cyc_d, acc_q, acc_d, sum;
    logic [7:0] rate_q, rate_d, sec_q, sec_d, prof_sec, prof_rate;
    logic pulse_q, pulse_d, done_q, done_d, fire, last, to_done;

    // In IDLE the profile sees the incoming mode so the first rate is ready on the start edge.
    assign prof_mode = state_q == IDLE ? bus.mode : mode_q;
    assign prof_sec = state_q == IDLE ? 8'd1 : sec_q + 8'd1;

    step_rate_profile u_profile (
        .mode_i(prof_mode),
        .sec_i (prof_sec),
        .rate_o(prof_rate)
    );

    assign sum = acc_q + CW'(rate_q);
    assign fire = sum >= HZ;
    assign last = cyc_q == LAST_CYC;
    assign to_done = state_q == RUN && mode_q == MODE_HYBRID && last && sec_q == HYBRID_LAST_SEC;

    always_ff @(posedge step_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q <= MODE_32;
            cyc_q <= '0;
            acc_q <= '0;
            rate_q <= '0;
            sec_q <= '0;
            pulse_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q <= mode_d;
            cyc_q <= cyc_d;
            acc_q <= acc_d;
            rate_q <= rate_d;
            sec_q <= sec_d;
            pulse_q <= pulse_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        state_d = !bus.start ? IDLE : state_q == IDLE ? RUN : to_done ? DONE : state_q;
    end

    // Dropping start clears everything, including a pulse decided on the same edge.
    always_comb begin
        mode_d = mode_q;
        cyc_d = '0;
        acc_d = '0;
        rate_d = '0;
        sec_d = '0;
        pulse_d = 1'b0;
        done_d = 1'b0;
        if (bus.start && state_q == IDLE) begin
            mode_d = bus.mode;
            sec_d = 8'd1;
            rate_d = prof_rate;
        end else if (bus.start && state_q == RUN) begin
            pulse_d = fire;
            cyc_d = last ? '0 : cyc_q + 1'b1;
            acc_d = last ? '0 : fire ? sum - HZ : sum;
            rate_d = !last ? rate_q : to_done ? 8'd0 : prof_rate;
            sec_d = !last ? sec_q : to_done ? HYBRID_LAST_SEC + 8'd1 : sec_q == 8'hff ? sec_q : sec_q + 8'd1;
            done_d = to_done;
        end else if (bus.start && state_q == DONE) begin
            sec_d = HYBRID_LAST_SEC + 8'd1;
            done_d = 1'b1;
        end
    end

    assign bus.step_pulse = pulse_q;
    assign bus.rate = rate_q;
    assign bus.sec_count = sec_q;
    assign bus.hybrid_done = done_q;
endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: scoreboard bench comparing the generator against a cycle model every clock.
module tb_step_pulse_gen;
    import step_gen_pkg::*;

    localparam int HZ = 300;

    logic step_clk = 1'b0;
    logic reset;
    logic [17:0] obs;
    logic [17:0] exp_q[$];
    int n_vec = 0, n_err = 0;
    int m_state, m_cyc;
    logic [1:0] m_mode;
    logic [7:0] m_rate, m_sec;
    logic m_pulse, m_done;
    int sec_cnt[256];
    int total, b2b, last_p, gmin, gmax, cyc_no;
    logic prev_p, found;

    step_pulse_gen_if bus ();

    step_pulse_gen #(.CLK_HZ(HZ), .CW(9)) dut (
        .step_clk(step_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 step_clk = ~step_clk;

    assign obs = {bus.step_pulse, bus.rate, bus.sec_count, bus.hybrid_done};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [7:0] rate_of(input logic [1:0] m, input int s);
        if (m != 2'd3) return 8'(32 << m);
        case (s)
            1: return 8'd20;
            2: return 8'd33;
            3: return 8'd66;
            4: return 8'd27;
            5: return 8'd70;
            6: return 8'd30;
            7: return 8'd19;
            8: return 8'd30;
            9: return 8'd33;
            default: return (s < 1 || s > 144) ? 8'd0 : s <= 73 ? 8'd69 : s <= 79 ? 8'd34 : 8'd124;
        endcase
    endfunction

    function automatic logic fire_now();
        return m_state == 1 && bus.start && ((m_cyc + 1) * int'(m_rate)) / HZ > (m_cyc * int'(m_rate)) / HZ;
    endfunction

    task automatic model_clear();
        m_state = 0;
        m_cyc = 0;
        m_mode = 2'd0;
        m_rate = 8'd0;
        m_sec = 8'd0;
        m_pulse = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_step();
        logic f;
        f = fire_now();
        if (!bus.start) begin
            model_clear();
        end else if (m_state == 0) begin
            m_state = 1;
            m_mode = bus.mode;
            m_sec = 8'd1;
            m_cyc = 0;
            m_rate = rate_of(m_mode, 1);
            m_pulse = 1'b0;
            m_done = 1'b0;
        end else if (m_state == 1) begin
            m_pulse = f;
            if (m_cyc == HZ - 1) begin
                m_cyc = 0;
                if (m_mode == 2'd3 && m_sec == 8'd144) begin
                    m_state = 2;
                    m_sec = 8'd145;
                    m_rate = 8'd0;
                    m_done = 1'b1;
                end else begin
                    m_sec = m_sec == 8'd255 ? m_sec : m_sec + 8'd1;
                    if (m_mode == 2'd3) m_rate = rate_of(m_mode, int'(m_sec));
                end
            end else begin
                m_cyc++;
            end
        end else begin
            m_pulse = 1'b0;
        end
    endtask

    task automatic clr();
        foreach (sec_cnt[i]) sec_cnt[i] = 0;
        total = 0;
        b2b = 0;
        last_p = -1;
        gmin = 1 << 30;
        gmax = 0;
    endtask

    task automatic tick();
        int ds;
        logic [17:0] e;
        ds = int'(m_sec);
        model_step();
        exp_q.push_back({m_pulse, m_rate, m_sec, m_done});
        @(posedge step_clk);
        @(negedge step_clk);
        e = exp_q.pop_front();
        chk("out", 32'(obs), 32'(e));
        if (bus.step_pulse) begin
            sec_cnt[ds]++;
            total++;
            if (prev_p) b2b++;
            if (last_p >= 0) begin
                gmin = (cyc_no - last_p) < gmin ? cyc_no - last_p : gmin;
                gmax = (cyc_no - last_p) > gmax ? cyc_no - last_p : gmax;
            end
            last_p = cyc_no;
        end
        prev_p = bus.step_pulse;
        cyc_no++;
    endtask

    initial begin
        model_clear();
        clr();
        cyc_no = 0;
        prev_p = 1'b0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.mode = MODE_32;
        repeat (2) @(negedge step_clk);
        chk("reset_out", 32'(obs), 32'd0);
        reset = 1'b0;

        bus.start = 1'b1;
        tick();
        chk("start_rate", 32'(bus.rate), 32'd32);
        chk("start_sec", 32'(bus.sec_count), 32'd1);
        repeat (HZ + HZ / 2) tick();
        bus.mode = MODE_128;
        repeat (3 * HZ - HZ - HZ / 2) tick();
        chk("fixed_sec4", 32'(bus.sec_count), 32'd4);
        chk("fixed_rate", 32'(bus.rate), 32'd32);
        for (int s = 1; s <= 3; s++) chk("fixed_cnt32", 32'(sec_cnt[s]), 32'd32);
        chk("fixed_total", 32'(total), 32'd96);

        bus.start = 1'b0;
        tick();
        chk("idle_out", 32'(obs), 32'd0);
        bus.start = 1'b1;
        clr();
        tick();
        chk("rerun_rate", 32'(bus.rate), 32'd128);
        chk("rerun_sec", 32'(bus.sec_count), 32'd1);
        repeat (2 * HZ) tick();
        chk("m128_cnt1", 32'(sec_cnt[1]), 32'd128);
        chk("m128_cnt2", 32'(sec_cnt[2]), 32'd128);
        chk("m128_gap_min", 32'(gmin), 32'(HZ / 128));
        chk("m128_gap_max", 32'(gmax), 32'(HZ / 128 + 1));
        chk("m128_b2b", 32'(b2b), 32'd0);

        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (fire_now()) found = 1'b1;
            else tick();
        end
        chk("drop_found", 32'(found), 32'd1);
        bus.start = 1'b0;
        tick();
        chk("drop_pulse", 32'(bus.step_pulse), 32'd0);
        chk("drop_sec", 32'(bus.sec_count), 32'd0);

        bus.mode = MODE_HYBRID;
        bus.start = 1'b1;
        clr();
        tick();
        chk("hyb_rate1", 32'(bus.rate), 32'd20);
        repeat (144 * HZ) tick();
        chk("hyb_cnt1", 32'(sec_cnt[1]), 32'd20);
        chk("hyb_cnt10", 32'(sec_cnt[10]), 32'd69);
        chk("hyb_cnt80", 32'(sec_cnt[80]), 32'd124);
        chk("hyb_total", 32'(total), 32'd13008);
        chk("hyb_done", 32'(bus.hybrid_done), 32'd1);
        chk("hyb_sec", 32'(bus.sec_count), 32'd145);
        chk("hyb_rate0", 32'(bus.rate), 32'd0);
        chk("hyb_b2b", 32'(b2b), 32'd0);
        total = 0;
        repeat (HZ) tick();
        chk("hyb_quiet", 32'(total), 32'd0);

        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        repeat (HZ + HZ / 2) tick();
        chk("pre_arst_rate", 32'(bus.rate), 32'd33);
        #2 reset = 1'b1;
        #1 chk("arst_out", 32'(obs), 32'd0);
        #1 reset = 1'b0;
        model_clear();
        tick();
        chk("arst_rate", 32'(bus.rate), 32'd20);
        chk("arst_sec", 32'(bus.sec_count), 32'd1);
        repeat (HZ) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
